soric_bank_xbar: RTL and testbench
==================================

// Module: soric_bank_xbar
// PURPOSE
//  Parametrised NMASTER x NBANK crossbar between core OBI-style data ports (req/gnt/rvalid) and
//  1RW SRAM banks (active-low csb/web, 1-cycle read latency). Per-bank round-robin arbitration,
//  parallel access to distinct banks, registered response routing. Sits between cores and SRAM macros.
// PARAMETERS
//  NMASTER      2   number of master ports (>=1)
//  NBANK        4   number of SRAM banks (power of 2, >=1)
//  ADDR_W       14  master byte-address width
//  BANK_ADDR_W  11  byte-address bits per bank (2kB); SRAM word addr = BANK_ADDR_W-2 bits
//  DATA_W       32  data width (be width = DATA_W/8)
// PORTS
//  clk_i       in   1                      clock
//  rst_ni      in   1                      asynchronous reset, active-low
//  m_req_i     in   NMASTER                master request
//  m_addr_i    in   NMASTER*ADDR_W         master byte address
//  m_we_i      in   NMASTER                1 = write
//  m_be_i      in   NMASTER*DATA_W/8       byte enables
//  m_wdata_i   in   NMASTER*DATA_W         write data
//  m_gnt_o     out  NMASTER                request accepted this cycle
//  m_rvalid_o  out  NMASTER                response valid (reads and writes)
//  m_rdata_o   out  NMASTER*DATA_W         read data, valid with rvalid
//  m_err_o     out  NMASTER                error response, valid with rvalid
//  s_csb_o     out  NBANK                  bank chip select, active-low
//  s_web_o     out  NBANK                  bank write enable, active-low
//  s_wmask_o   out  NBANK*DATA_W/8         bank write mask
//  s_addr_o    out  NBANK*(BANK_ADDR_W-2)  bank word address
//  s_wdata_o   out  NBANK*DATA_W           bank write data
//  s_rdata_i   in   NBANK*DATA_W           bank read data, 1 cycle after csb low
// BEHAVIOUR
//  - Decode: bank = addr[BANK_ADDR_W +: log2(NBANK)]; word = addr[BANK_ADDR_W-1:2]; addr[1:0] ignored.
//  - Per bank: round-robin among masters requesting it; search starts at ptr[b]. Grant is
//    combinational: m_gnt_o[m]=1 same cycle as req iff m wins its bank. ptr[b] <= winner+1 mod NMASTER
//    only on a grant; unchanged when bank idle.
//  - Granted bank: csb=0, web=~we, wmask=be, addr/wdata from winner. Idle bank: csb=1, web=1,
//    wmask=0, addr/wdata=0. Losing masters hold req (gnt=0), no state change.
//  - Distinct banks granted in same cycle; up to min(NMASTER,NBANK) accesses/cycle.
//  - Response: rvalid[m] exactly 1 cycle after gnt[m], for read and write; rdata=s_rdata_i of bank
//    latched with grant; write rvalid carries rdata=0. Back-to-back grants give back-to-back rvalid.
//  - No outstanding limit beyond 1 per master per cycle; latency fixed at 1.
//  - Reset (async, any time): ptr=0, rvalid=0, err=0, rdata=0; in-flight responses discarded;
//    gnt=0 and all csb=1 while rst_ni=0.
// CONFIGURATION
//  SORIC_XBAR_ERR_EN defined: addr bits above bank field nonzero -> out-of-range: gnt=1 same cycle
//    without arbitration or bank access, rvalid+err=1 next cycle, rdata=ERR_RDATA (32'hDEAD_BEEF).
//  Undefined: upper bits ignored (aliasing onto bank space); m_err_o tied 0.
// STRUCTURE
//  - soric_xbar_pkg: BANK_SEL_W/clog2 helper, ERR_RDATA constant, bank_idx() decode function.
//  - Sub-module soric_rr_arbiter (NMASTER-wide req->one-hot gnt, pointer register), one per bank.
//  - Top: decode, NBANK arbiter instances, bank muxes, per-master response regs (valid, bank idx, we, err).
// TESTING
//  1 Reset: rst_ni=0 mid-read -> next cycle rvalid=0, all s_csb_o=1; ptr restarts at master 0.
//  2 M0 write 0x0040 data 0xA5A5_0001 be=F, then read 0x0040 -> rvalid next cycle, rdata=0xA5A5_0001.
//  3 M0 addr 0x0000 (bank0), M1 addr 0x0800 (bank1) same cycle -> both gnt, both rvalid next cycle.
//  4 M0,M1 both hold bank2 (0x1000) 4 cycles -> grants alternate M0,M1,M0,M1; rvalid follows by 1.
//  5 Byte write be=4'b0010 data 0x0000_7700 over 0xFFFF_FFFF -> read returns 0xFFFF_77FF.
//  6 ERR_EN: read 0x2000 -> gnt same cycle, no csb low, next cycle rvalid=1 err=1 rdata=0xDEAD_BEEF;
//    without macro same access hits bank0 word 0.

Source files
------------

// File: rtl/soric_xbar_pkg.sv
// Shared constants and address-decode helpers for the SRAM bank crossbar.
package soric_xbar_pkg;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    // Select-field width; a single bank still gets a 1-bit index so vectors never collapse to zero width.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned bank_idx(input logic [63:0] addr,
                                             input int unsigned bank_addr_w,
                                             input int unsigned nbank);
        return 32'((addr >> bank_addr_w) & 64'(nbank - 1));
    endfunction

    function automatic logic above_bank(input logic [63:0] addr, input int unsigned low);
        return (addr >> low) != '0;
    endfunction

endpackage

// File: rtl/soric_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts at the pointer,
// pointer moves past the winner only when something is granted.
module soric_rr_arbiter
    import soric_xbar_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = sel_w(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt;
    logic          hit;
    int unsigned   idx;

    always_comb begin
        gnt = '0;
        hit = 1'b0;
        nxt = ptr;
        idx = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!hit && req[idx]) begin
                hit      = 1'b1;
                gnt[idx] = 1'b1;
                nxt      = PW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (hit)
            ptr <= nxt;
    end

endmodule

// File: rtl/soric_bank_xbar.sv
// NMASTER x NBANK crossbar from OBI-style master ports to 1RW SRAM banks, fixed 1-cycle response.
// Optional SORIC_XBAR_ERR_EN: addresses above the bank space get an immediate error response.
module soric_bank_xbar
    import soric_xbar_pkg::*;
#(
    parameter int unsigned NMASTER     = 2,
    parameter int unsigned NBANK       = 4,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned BANK_ADDR_W = 11,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NMASTER-1:0]              m_req_i,
    input  logic [NMASTER*ADDR_W-1:0]       m_addr_i,
    input  logic [NMASTER-1:0]              m_we_i,
    input  logic [NMASTER*DATA_W/8-1:0]     m_be_i,
    input  logic [NMASTER*DATA_W-1:0]       m_wdata_i,
    output logic [NMASTER-1:0]              m_gnt_o,
    output logic [NMASTER-1:0]              m_rvalid_o,
    output logic [NMASTER*DATA_W-1:0]       m_rdata_o,
    output logic [NMASTER-1:0]              m_err_o,
    output logic [NBANK-1:0]                s_csb_o,
    output logic [NBANK-1:0]                s_web_o,
    output logic [NBANK*DATA_W/8-1:0]       s_wmask_o,
    output logic [NBANK*(BANK_ADDR_W-2)-1:0] s_addr_o,
    output logic [NBANK*DATA_W-1:0]         s_wdata_o,
    input  logic [NBANK*DATA_W-1:0]         s_rdata_i
);

    localparam int unsigned BE_W       = DATA_W / 8;
    localparam int unsigned WA_W       = BANK_ADDR_W - 2;
    localparam int unsigned BANK_SEL_W = sel_w(NBANK);

    logic [NMASTER-1:0]                oor;
    logic [BANK_SEL_W-1:0]             m_bank [NMASTER];
    logic [NBANK-1:0][NMASTER-1:0]     bank_req;
    logic [NBANK-1:0][NMASTER-1:0]     bank_gnt;

    logic [NMASTER-1:0]                rv_q, we_q, err_q;
    logic [BANK_SEL_W-1:0]             bank_q [NMASTER];

    always_comb begin
        bank_req = '0;
        oor      = '0;
        for (int unsigned m = 0; m < NMASTER; m++) begin
            m_bank[m] = BANK_SEL_W'(bank_idx(64'(m_addr_i[m*ADDR_W +: ADDR_W]), BANK_ADDR_W, NBANK));
`ifdef SORIC_XBAR_ERR_EN
            oor[m] = above_bank(64'(m_addr_i[m*ADDR_W +: ADDR_W]), BANK_ADDR_W + $clog2(NBANK));
`endif
            if (rst_ni && m_req_i[m] && !oor[m])
                bank_req[m_bank[m]][m] = 1'b1;
        end
    end

    // Out-of-range requests are accepted straight away, bypassing arbitration.
    always_comb begin
        m_gnt_o = rst_ni ? (m_req_i & oor) : '0;
        for (int unsigned b = 0; b < NBANK; b++)
            m_gnt_o = m_gnt_o | bank_gnt[b];
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [WA_W-1:0]   addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   wmask;
        logic              we;

        soric_rr_arbiter #(.N(NMASTER)) u_arb (
            .clk   (clk_i),
            .rst_n (rst_ni),
            .req   (bank_req[b]),
            .gnt   (bank_gnt[b])
        );

        always_comb begin
            addr  = '0;
            wdata = '0;
            wmask = '0;
            we    = 1'b0;
            for (int unsigned m = 0; m < NMASTER; m++) begin
                if (bank_gnt[b][m]) begin
                    addr  = m_addr_i[m*ADDR_W+2 +: WA_W];
                    wdata = m_wdata_i[m*DATA_W +: DATA_W];
                    wmask = m_be_i[m*BE_W +: BE_W];
                    we    = m_we_i[m];
                end
            end
        end

        assign s_csb_o[b]                = ~|bank_gnt[b];
        assign s_web_o[b]                = ~we;
        assign s_wmask_o[b*BE_W +: BE_W] = wmask;
        assign s_addr_o[b*WA_W +: WA_W]  = addr;
        assign s_wdata_o[b*DATA_W +: DATA_W] = wdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rv_q  <= '0;
            we_q  <= '0;
            err_q <= '0;
            for (int unsigned m = 0; m < NMASTER; m++)
                bank_q[m] <= '0;
        end else begin
            rv_q  <= m_gnt_o;
            we_q  <= m_we_i;
            err_q <= oor;
            for (int unsigned m = 0; m < NMASTER; m++)
                bank_q[m] <= m_bank[m];
        end
    end

    always_comb begin
        m_rvalid_o = rv_q;
        m_err_o    = rv_q & err_q;
        m_rdata_o  = '0;
        for (int unsigned m = 0; m < NMASTER; m++) begin
            if (rv_q[m] && err_q[m])
                m_rdata_o[m*DATA_W +: DATA_W] = DATA_W'(ERR_RDATA);
            else if (rv_q[m] && !we_q[m])
                m_rdata_o[m*DATA_W +: DATA_W] = s_rdata_i[bank_q[m]*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_soric_bank_xbar.sv
// Scoreboard bench for soric_bank_xbar: SRAM bank models, reference memory/arbitration model,
// directed scenarios followed by randomized traffic.
module tb_soric_bank_xbar;

    localparam int NM = 2, NB = 4, AW = 14, BAW = 11, DW = 32, BEW = 4, WAW = 9, WORDS = 512;

    logic              clk_i, rst_ni;
    logic [NM-1:0]     m_req_i, m_we_i, m_gnt_o, m_rvalid_o, m_err_o;
    logic [NM*AW-1:0]  m_addr_i;
    logic [NM*BEW-1:0] m_be_i;
    logic [NM*DW-1:0]  m_wdata_i, m_rdata_o;
    logic [NB-1:0]     s_csb_o, s_web_o;
    logic [NB*BEW-1:0] s_wmask_o;
    logic [NB*WAW-1:0] s_addr_o;
    logic [NB*DW-1:0]  s_wdata_o, s_rdata_i;

    soric_bank_xbar #(.NMASTER(NM), .NBANK(NB), .ADDR_W(AW), .BANK_ADDR_W(BAW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
        .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
        .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
        .s_csb_o(s_csb_o), .s_web_o(s_web_o), .s_wmask_o(s_wmask_o),
        .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // SRAM macros: masked write, 1-cycle registered read
    logic [31:0] sram [NB][WORDS];
    logic [31:0] srd  [NB];
    always @(posedge clk_i)
        for (int b = 0; b < NB; b++)
            if (!s_csb_o[b]) begin
                if (!s_web_o[b]) begin
                    for (int i = 0; i < BEW; i++)
                        if (s_wmask_o[b*BEW+i])
                            sram[b][s_addr_o[b*WAW +: WAW]][8*i +: 8] <= s_wdata_o[b*DW + 8*i +: 8];
                end else
                    srd[b] <= sram[b][s_addr_o[b*WAW +: WAW]];
            end
    always_comb
        for (int b = 0; b < NB; b++) s_rdata_i[b*DW +: DW] = srd[b];

    typedef struct { logic [31:0] rdata; logic err; int due; } exp_t;
    exp_t        sbq [NM][$];
    logic [31:0] ref_mem [NB*WORDS];
    int          ptr_m [NB];
    int          vectors = 0, miscompares = 0, cyc = 0;

    logic [NM-1:0] p_req, p_we;
    logic [13:0]   p_addr [NM];
    logic [3:0]    p_be   [NM];
    logic [31:0]   p_wd   [NM];

    always @(posedge clk_i) cyc++;

    function automatic bit is_oor(input logic [13:0] a);
`ifdef SORIC_XBAR_ERR_EN
        return (a >> (BAW + 2)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int bank_of(input logic [13:0] a); return (int'(a) >> BAW) % NB; endfunction
    function automatic int word_of(input logic [13:0] a); return (int'(a) >> 2) % WORDS; endfunction

    task automatic check_cycle(output logic [NM-1:0] eg);
        logic [NB-1:0] ecsb;
        exp_t it;
        int m, idx;
        eg = '0;
        ecsb = '1;
        if (rst_ni) begin
            for (int k = 0; k < NM; k++)
                if (p_req[k] && is_oor(p_addr[k])) eg[k] = 1'b1;
            for (int b = 0; b < NB; b++)
                for (int k = 0; k < NM; k++) begin
                    m = (ptr_m[b] + k) % NM;
                    if (ecsb[b] && p_req[m] && !is_oor(p_addr[m]) && bank_of(p_addr[m]) == b) begin
                        eg[m] = 1'b1;
                        ecsb[b] = 1'b0;
                        ptr_m[b] = (m + 1) % NM;
                    end
                end
        end else if (m_rvalid_o !== '0) begin
            miscompares++;
            $display("FAIL reset_rvalid: got %b want 0", m_rvalid_o);
        end
        vectors++;
        if (m_gnt_o !== eg) begin
            miscompares++;
            $display("FAIL gnt cyc=%0d: got %b want %b", cyc, m_gnt_o, eg);
        end
        if (s_csb_o !== ecsb) begin
            miscompares++;
            $display("FAIL csb cyc=%0d: got %b want %b", cyc, s_csb_o, ecsb);
        end
        for (int k = 0; k < NM; k++)
            if (eg[k]) begin
                idx = bank_of(p_addr[k]) * WORDS + word_of(p_addr[k]);
                it.err = is_oor(p_addr[k]);
                it.due = cyc + 1;
                it.rdata = it.err ? 32'hDEAD_BEEF : (p_we[k] ? 32'h0 : ref_mem[idx]);
                if (p_we[k] && !it.err)
                    for (int i = 0; i < 4; i++)
                        if (p_be[k][i]) ref_mem[idx][8*i +: 8] = p_wd[k][8*i +: 8];
                sbq[k].push_back(it);
            end
    endtask

    always @(negedge clk_i)
        for (int m = 0; m < NM; m++) begin
            if (m_rvalid_o[m]) begin
                if (sbq[m].size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rvalid m%0d cyc=%0d", m, cyc);
                end else begin
                    exp_t e;
                    e = sbq[m].pop_front();
                    if (m_rdata_o[m*DW +: DW] !== e.rdata || m_err_o[m] !== e.err || e.due != cyc) begin
                        miscompares++;
                        $display("FAIL resp m%0d cyc=%0d: got rdata=%h err=%b want rdata=%h err=%b due=%0d",
                                 m, cyc, m_rdata_o[m*DW +: DW], m_err_o[m], e.rdata, e.err, e.due);
                    end
                end
            end else if (sbq[m].size() > 0 && sbq[m][0].due <= cyc) begin
                miscompares++;
                $display("FAIL missing_rvalid m%0d cyc=%0d: got rvalid=0 want 1", m, cyc);
                void'(sbq[m].pop_front());
            end
        end

    task automatic step(output logic [NM-1:0] g);
        for (int m = 0; m < NM; m++) begin
            m_req_i[m] = p_req[m];
            m_we_i[m]  = p_we[m];
            m_addr_i[m*AW +: AW]   = p_addr[m];
            m_be_i[m*BEW +: BEW]   = p_be[m];
            m_wdata_i[m*DW +: DW]  = p_wd[m];
        end
        @(negedge clk_i);
        check_cycle(g);
        @(posedge clk_i);
        #1;
    endtask

    task automatic set(input int m, input logic r, input logic w, input logic [13:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
        p_req[m] = r; p_we[m] = w; p_addr[m] = a; p_be[m] = be; p_wd[m] = wd;
    endtask

    task automatic rnd(input int m);
        int a;
        a = ($urandom_range(7) == 0 ? 1 << 13 : 0) | ($urandom_range(3) << 11)
          | ($urandom_range(7) << 2) | $urandom_range(3);
        set(m, $urandom_range(3) != 0, 1'($urandom_range(1)), 14'(a), 4'($urandom_range(15)), $urandom);
    endtask

    task automatic idle();
        for (int m = 0; m < NM; m++) set(m, 1'b0, 1'b0, '0, '0, '0);
    endtask

    logic [NM-1:0] g;

    initial begin
        for (int b = 0; b < NB; b++) begin
            srd[b] = '0;
            ptr_m[b] = 0;
            for (int w = 0; w < WORDS; w++) begin
                sram[b][w] = '0;
                ref_mem[b*WORDS + w] = '0;
            end
        end
        rst_ni = 1'b0;
        idle();
        set(0, 1'b1, 1'b0, 14'h0040, 4'hF, '0);
        repeat (2) step(g);
        rst_ni = 1'b1;
        idle();
        step(g);

        set(0, 1'b1, 1'b1, 14'h0040, 4'hF, 32'hA5A5_0001); step(g);
        set(0, 1'b1, 1'b0, 14'h0040, 4'hF, '0);           step(g);
        idle(); step(g);

        set(0, 1'b1, 1'b0, 14'h0000, 4'hF, '0);
        set(1, 1'b1, 1'b0, 14'h0800, 4'hF, '0);
        step(g);
        idle(); step(g);

        set(0, 1'b1, 1'b0, 14'h1000, 4'hF, '0);
        set(1, 1'b1, 1'b0, 14'h1000, 4'hF, '0);
        repeat (4) step(g);
        idle(); step(g);

        set(0, 1'b1, 1'b1, 14'h0080, 4'hF, 32'hFFFF_FFFF); step(g);
        set(0, 1'b1, 1'b1, 14'h0080, 4'b0010, 32'h0000_7700); step(g);
        set(0, 1'b1, 1'b0, 14'h0080, 4'hF, '0); step(g);
        idle(); step(g);

        set(0, 1'b1, 1'b0, 14'h2000, 4'hF, '0); step(g);
        idle(); step(g);

        // Reset asserted while a read response is in flight
        set(1, 1'b1, 1'b0, 14'h1004, 4'hF, '0); step(g);
        step(g);
        rst_ni = 1'b0;
        for (int m = 0; m < NM; m++) sbq[m].delete();
        for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        step(g);
        rst_ni = 1'b1;
        set(0, 1'b1, 1'b0, 14'h1000, 4'hF, '0);
        set(1, 1'b1, 1'b0, 14'h1000, 4'hF, '0);
        repeat (2) step(g);
        idle(); step(g);

        for (int m = 0; m < NM; m++) rnd(m);
        repeat (600) begin
            step(g);
            for (int m = 0; m < NM; m++)
                if (g[m] || !p_req[m]) rnd(m);
        end
        idle();
        repeat (3) step(g);
        for (int m = 0; m < NM; m++)
            if (sbq[m].size() != 0) begin
                miscompares++;
                $display("FAIL drain m%0d: got %0d pending want 0", m, sbq[m].size());
            end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
